// File: rtl/assoc_dcache.sv
`default_nettype none
// ============================================================================
// Module : assoc_dcache
// N-way set-associative, write-back, write-allocate L1 data cache with
// round-robin replacement and a full-cache flush walk.
// Rev    : 1.0
// ============================================================================
module assoc_dcache #(
  parameter int WAYS       = 2,
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     RESET,
  input  logic                     cpu_req_valid,
  output logic                     cpu_req_ready,
  input  logic [ADDR_WIDTH-1:0]    cpu_req_addr,
  input  logic                     cpu_req_we,
  input  logic [3:0]               cpu_req_be,
  input  logic [31:0]              cpu_req_wdata,
  output logic                     cpu_resp_valid,
  output logic [31:0]              cpu_resp_rdata,
  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic                     mem_req_we,
  output logic [ADDR_WIDTH-1:0]    mem_req_addr,
  output logic [32*LINE_WORDS-1:0] mem_req_wdata,
  input  logic                     mem_resp_valid,
  input  logic [32*LINE_WORDS-1:0] mem_resp_rdata,
  input  logic                     flush,
  output logic                     flush_done
);
  localparam int OFF_BITS = $clog2(LINE_WORDS * 4);
  localparam int IDX_BITS = $clog2(SETS);
  localparam int TAG_W    = ADDR_WIDTH - OFF_BITS - IDX_BITS;
  localparam int LINE_W   = 32 * LINE_WORDS;
  localparam int WO_BITS  = $clog2(LINE_WORDS);
  localparam int WB       = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_LOOKUP, S_WB_REQ, S_WB_WAIT, S_FILL_REQ, S_FILL_WAIT, S_RESPOND,
    S_FLUSH_SCAN, S_FLUSH_WB_REQ, S_FLUSH_WB_WAIT, S_FLUSH_DONE
  } state_t;

  state_t                   state_q;
  logic [LINE_W-1:0]        data_q  [WAYS][SETS];
  logic [TAG_W-1:0]         tag_q   [WAYS][SETS];
  logic                     valid_q [WAYS][SETS];
  logic                     dirty_q [WAYS][SETS];
  logic [WB-1:0]            rr_q    [SETS];
  logic [ADDR_WIDTH-1:2]    addr_q;
  logic                     we_q;
  logic [3:0]               be_q;
  logic [31:0]              wdata_q;
  logic [WB-1:0]            way_q;
  logic                     evict_q;
  logic [ADDR_WIDTH-1:0]    mem_addr_q;
  logic [LINE_W-1:0]        mem_wdata_q;
  logic [31:0]              rdata_q;
  logic [IDX_BITS-1:0]      fset_q;
  logic [WB-1:0]            fway_q;

  logic [IDX_BITS-1:0]      idx;
  logic [TAG_W-1:0]         tag;
  logic [WO_BITS-1:0]       woff;
  logic [ADDR_WIDTH-1:0]    fill_addr;
  logic                     hit, found_inv;
  logic [WB-1:0]            hit_way, victim;
  logic                     arr_we, arr_tag_we;
  logic [WB-1:0]            arr_way;
  logic [LINE_W-1:0]        arr_line, resp_line;
  logic [31:0]              resp_word;
  logic                     flush_last;
  logic                     unused_addr_bits;

  assign unused_addr_bits = ^cpu_req_addr[1:0];

  assign idx       = addr_q[OFF_BITS +: IDX_BITS];
  assign tag       = addr_q[ADDR_WIDTH-1 -: TAG_W];
  assign woff      = addr_q[2 +: WO_BITS];
  assign fill_addr = {addr_q[ADDR_WIDTH-1:OFF_BITS], {OFF_BITS{1'b0}}};
  assign flush_last = (fset_q == IDX_BITS'(SETS - 1)) && (fway_q == WB'(WAYS - 1));

  function automatic logic [LINE_W-1:0] merge(input logic [LINE_W-1:0] line,
                                               input logic [WO_BITS-1:0] wi,
                                               input logic [3:0] be,
                                               input logic [31:0] wd);
    logic [LINE_W-1:0] r;
    r = line;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[int'(wi) * 32 + b * 8 +: 8] = wd[b * 8 +: 8];
    return r;
  endfunction

  // Victim is the lowest invalid way; only when the set is full does rr_q decide.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    found_inv = 1'b0;
    victim    = rr_q[idx];
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[w][idx] && (tag_q[w][idx] == tag)) begin
        hit     = 1'b1;
        hit_way = WB'(w);
      end
      if (!valid_q[w][idx] && !found_inv) begin
        found_inv = 1'b1;
        victim    = WB'(w);
      end
    end
  end

  always_comb begin
    arr_we     = 1'b0;
    arr_tag_we = 1'b0;
    arr_way    = hit_way;
    arr_line   = '0;
    if (state_q == S_LOOKUP && hit && we_q) begin
      arr_we   = 1'b1;
      arr_line = merge(data_q[hit_way][idx], woff, be_q, wdata_q);
    end else if (state_q == S_FILL_WAIT && mem_resp_valid) begin
      arr_we     = 1'b1;
      arr_tag_we = 1'b1;
      arr_way    = way_q;
      arr_line   = we_q ? merge(mem_resp_rdata, woff, be_q, wdata_q) : mem_resp_rdata;
    end
    resp_line = arr_we ? arr_line : data_q[hit_way][idx];
    resp_word = resp_line[int'(woff) * 32 +: 32];
  end

  always_ff @(posedge clk) begin
    if (arr_we) begin
      data_q[arr_way][idx] <= arr_line;
      if (arr_tag_we) tag_q[arr_way][idx] <= tag;
    end
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      we_q        <= 1'b0;
      be_q        <= '0;
      wdata_q     <= '0;
      way_q       <= '0;
      evict_q     <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      fset_q      <= '0;
      fway_q      <= '0;
      for (int s = 0; s < SETS; s++) begin
        rr_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          valid_q[w][s] <= 1'b0;
          dirty_q[w][s] <= 1'b0;
        end
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (flush) begin
            fset_q  <= '0;
            fway_q  <= '0;
            state_q <= S_FLUSH_SCAN;
          end else if (cpu_req_valid) begin
            addr_q  <= cpu_req_addr[ADDR_WIDTH-1:2];
            we_q    <= cpu_req_we;
            be_q    <= cpu_req_be;
            wdata_q <= cpu_req_wdata;
            state_q <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (hit) begin
            if (we_q) dirty_q[hit_way][idx] <= 1'b1;
            rdata_q <= resp_word;
            state_q <= S_RESPOND;
          end else begin
            way_q   <= victim;
            evict_q <= valid_q[victim][idx];
            if (valid_q[victim][idx] && dirty_q[victim][idx]) begin
              mem_addr_q  <= {tag_q[victim][idx], idx, {OFF_BITS{1'b0}}};
              mem_wdata_q <= data_q[victim][idx];
              state_q     <= S_WB_REQ;
            end else begin
              mem_addr_q <= fill_addr;
              state_q    <= S_FILL_REQ;
            end
          end
        end
        S_WB_REQ:  if (mem_req_ready) state_q <= S_WB_WAIT;
        S_WB_WAIT: begin
          if (mem_resp_valid) begin
            mem_addr_q <= fill_addr;
            state_q    <= S_FILL_REQ;
          end
        end
        S_FILL_REQ: if (mem_req_ready) state_q <= S_FILL_WAIT;
        S_FILL_WAIT: begin
          if (mem_resp_valid) begin
            valid_q[way_q][idx] <= 1'b1;
            dirty_q[way_q][idx] <= we_q;
            if (evict_q) rr_q[idx] <= (rr_q[idx] == WB'(WAYS - 1)) ? '0 : rr_q[idx] + 1'b1;
            rdata_q <= resp_word;
            state_q <= S_RESPOND;
          end
        end
        S_RESPOND: state_q <= S_IDLE;
        S_FLUSH_SCAN, S_FLUSH_WB_WAIT: begin
          if (state_q == S_FLUSH_SCAN && valid_q[fway_q][fset_q] && dirty_q[fway_q][fset_q]) begin
            mem_addr_q  <= {tag_q[fway_q][fset_q], fset_q, {OFF_BITS{1'b0}}};
            mem_wdata_q <= data_q[fway_q][fset_q];
            state_q     <= S_FLUSH_WB_REQ;
          end else if (state_q == S_FLUSH_SCAN || mem_resp_valid) begin
            if (state_q == S_FLUSH_WB_WAIT) dirty_q[fway_q][fset_q] <= 1'b0;
            if (flush_last) begin
              state_q <= S_FLUSH_DONE;
            end else begin
              state_q <= S_FLUSH_SCAN;
              if (fway_q == WB'(WAYS - 1)) begin
                fway_q <= '0;
                fset_q <= fset_q + 1'b1;
              end else begin
                fway_q <= fway_q + 1'b1;
              end
            end
          end
        end
        S_FLUSH_WB_REQ: if (mem_req_ready) state_q <= S_FLUSH_WB_WAIT;
        S_FLUSH_DONE:   state_q <= S_IDLE;
        default:        state_q <= S_IDLE;
      endcase
    end
  end

  assign cpu_req_ready  = (state_q == S_IDLE) && !flush;
  assign cpu_resp_valid = (state_q == S_RESPOND);
  assign cpu_resp_rdata = rdata_q;
  assign mem_req_valid  = (state_q == S_WB_REQ) || (state_q == S_FILL_REQ) ||
                          (state_q == S_FLUSH_WB_REQ);
  assign mem_req_we     = (state_q == S_WB_REQ) || (state_q == S_FLUSH_WB_REQ);
  assign mem_req_addr   = mem_addr_q;
  assign mem_req_wdata  = mem_wdata_q;
  assign flush_done     = (state_q == S_FLUSH_DONE);

endmodule
`default_nettype wire

// File: tb/tb_assoc_dcache.sv
`default_nettype none
// ============================================================================
// Module : tb_assoc_dcache
// Directed bench for assoc_dcache: misses, hits, eviction, stall, flush, reset.
// Rev    : 1.0
// ============================================================================
module tb_assoc_dcache;
  logic         clk;
  logic         RESET;
  logic         cpu_req_valid, cpu_req_ready, cpu_req_we;
  logic [31:0]  cpu_req_addr, cpu_req_wdata, cpu_resp_rdata;
  logic [3:0]   cpu_req_be;
  logic         cpu_resp_valid;
  logic         mem_req_valid, mem_req_ready, mem_req_we;
  logic [31:0]  mem_req_addr;
  logic [127:0] mem_req_wdata, mem_resp_rdata;
  logic         mem_resp_valid;
  logic         flush, flush_done;

  int vectors    = 0;
  int miscompares = 0;

  // RAM model state and request log
  logic [127:0] ram [logic [31:0]];
  logic [31:0]  log_addr [$];
  logic         log_we   [$];
  logic [127:0] log_wdata[$];
  int           stall_left = 0;
  bit           ram_hang   = 1'b0;
  logic [31:0]  acc_addr;
  logic         acc_we;
  logic [127:0] acc_wdata;

  assoc_dcache dut (
    .clk(clk), .RESET(RESET),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
    .cpu_req_addr(cpu_req_addr), .cpu_req_we(cpu_req_we),
    .cpu_req_be(cpu_req_be), .cpu_req_wdata(cpu_req_wdata),
    .cpu_resp_valid(cpu_resp_valid), .cpu_resp_rdata(cpu_resp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_resp_valid(mem_resp_valid),
    .mem_resp_rdata(mem_resp_rdata), .flush(flush), .flush_done(flush_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] dflt_line(input logic [31:0] a);
    logic [127:0] r;
    for (int i = 0; i < 4; i++) r[i * 32 +: 32] = 32'hD000_0000 | a | 32'(i);
    return r;
  endfunction

  function automatic logic [32:0] log_req(input int i);
    if (i < log_addr.size()) return {log_we[i], log_addr[i]};
    return 'x;
  endfunction

  function automatic logic [127:0] log_data(input int i);
    if (i < log_wdata.size()) return log_wdata[i];
    return 'x;
  endfunction

  // Accepts one request per handshake and answers on the following cycle.
  initial begin : ram_model
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_rdata = '0;
    forever begin
      @(negedge clk);
      mem_resp_valid = 1'b0;
      if (mem_req_ready) begin
        mem_req_ready = 1'b0;
        if (!ram_hang) begin
          if (acc_we) ram[acc_addr] = acc_wdata;
          mem_resp_rdata = ram.exists(acc_addr) ? ram[acc_addr] : dflt_line(acc_addr);
          mem_resp_valid = 1'b1;
        end
      end else if (mem_req_valid && !RESET) begin
        if (stall_left > 0) begin
          stall_left--;
        end else begin
          mem_req_ready = 1'b1;
          acc_addr  = mem_req_addr;
          acc_we    = mem_req_we;
          acc_wdata = mem_req_wdata;
          log_addr.push_back(mem_req_addr);
          log_we.push_back(mem_req_we);
          log_wdata.push_back(mem_req_wdata);
        end
      end
    end
  end

  task automatic cpu_issue(input logic [31:0] a, input logic we, input logic [3:0] be,
                           input logic [31:0] wd);
    int n;
    @(negedge clk);
    cpu_req_valid = 1'b1; cpu_req_addr = a; cpu_req_we = we;
    cpu_req_be = be; cpu_req_wdata = wd;
    n = 0;
    while (!cpu_req_ready && n < 300) begin @(negedge clk); n++; end
    vectors++;
    if (!cpu_req_ready) begin
      miscompares++;
      $display("FAIL accept_timeout: addr %h never accepted, want ready=1", a);
    end
    @(posedge clk);
    #1 cpu_req_valid = 1'b0;
  endtask

  task automatic cpu_wait(output logic [31:0] d, output int lat);
    lat = 0;
    d   = 'x;
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      if (cpu_resp_valid) begin d = cpu_resp_rdata; break; end
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (cpu_req_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset_ready: got %b want 1", cpu_req_ready);
    end
    vectors++;
    if ({cpu_resp_valid, mem_req_valid, mem_req_we, flush_done} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b want 0000",
               {cpu_resp_valid, mem_req_valid, mem_req_we, flush_done});
    end
    vectors++;
    if (cpu_resp_rdata !== 32'h0 || mem_req_addr !== 32'h0 || mem_req_wdata !== 128'h0) begin
      miscompares++;
      $display("FAIL reset_data: rdata %h addr %h wdata %h want all zero",
               cpu_resp_rdata, mem_req_addr, mem_req_wdata);
    end
    RESET = 1'b0;
  endtask

  task automatic test_cold_miss();
    logic [31:0] d; int lat; int n0;
    n0 = log_addr.size();
    cpu_issue(32'h104, 1'b0, 4'h0, 32'h0);
    cpu_wait(d, lat);
    vectors++;
    if (d !== 32'h22) begin miscompares++; $display("FAIL cold_rdata: got %h want 00000022", d); end
    vectors++;
    if (log_addr.size() != n0 + 1 || log_req(n0) !== {1'b0, 32'h100}) begin
      miscompares++;
      $display("FAIL cold_fill: %0d reqs, first %h want 1 req 0_00000100", log_addr.size() - n0, log_req(n0));
    end
    n0 = log_addr.size();
    cpu_issue(32'h104, 1'b0, 4'h0, 32'h0);
    cpu_wait(d, lat);
    vectors++;
    if (d !== 32'h22 || lat != 2) begin
      miscompares++; $display("FAIL hit_read: got %h lat %0d want 00000022 lat 2", d, lat);
    end
    vectors++;
    if (log_addr.size() != n0) begin
      miscompares++; $display("FAIL hit_no_mem: got %0d reqs want 0", log_addr.size() - n0);
    end
  endtask

  task automatic test_write_hit();
    logic [31:0] d; int lat; int n0;
    n0 = log_addr.size();
    cpu_issue(32'h104, 1'b1, 4'b0010, 32'h0000AB00);
    cpu_wait(d, lat);
    vectors++;
    if (d !== 32'h0000AB22 || lat != 2) begin
      miscompares++; $display("FAIL write_hit_resp: got %h lat %0d want 0000ab22 lat 2", d, lat);
    end
    cpu_issue(32'h104, 1'b0, 4'h0, 32'h0);
    cpu_wait(d, lat);
    vectors++;
    if (d !== 32'h0000AB22 || log_addr.size() != n0) begin
      miscompares++;
      $display("FAIL write_hit_read: got %h reqs %0d want 0000ab22 reqs 0", d, log_addr.size() - n0);
    end
  endtask

  task automatic test_conflict();
    logic [31:0] d; int lat; int n0;
    cpu_issue(32'h100, 1'b1, 4'b1111, 32'hCAFE0000);
    cpu_wait(d, lat);
    n0 = log_addr.size();
    cpu_issue(32'h500, 1'b0, 4'h0, 32'h0);
    cpu_wait(d, lat);
    vectors++;
    if (d !== 32'hD0000500 || log_addr.size() != n0 + 1 || log_req(n0) !== {1'b0, 32'h500}) begin
      miscompares++;
      $display("FAIL fill_way1: got %h req %h want d0000500 req 0_00000500", d, log_req(n0));
    end
    n0 = log_addr.size();
    cpu_issue(32'h900, 1'b0, 4'h0, 32'h0);
    cpu_wait(d, lat);
    vectors++;
    if (d !== 32'hD0000900) begin miscompares++; $display("FAIL evict_rdata: got %h want d0000900", d); end
    vectors++;
    if (log_addr.size() != n0 + 2 || log_req(n0) !== {1'b1, 32'h100} || log_req(n0 + 1) !== {1'b0, 32'h900}) begin
      miscompares++;
      $display("FAIL evict_order: got %h then %h want 1_00000100 then 0_00000900", log_req(n0), log_req(n0 + 1));
    end
    vectors++;
    if (log_data(n0) !== {32'h44, 32'h33, 32'h0000AB22, 32'hCAFE0000}) begin
      miscompares++; $display("FAIL wb_line: got %h want 00000044000000330000ab22cafe0000", log_data(n0));
    end
    n0 = log_addr.size();
    cpu_issue(32'h100, 1'b0, 4'h0, 32'h0);
    cpu_wait(d, lat);
    vectors++;
    if (d !== 32'hCAFE0000 || log_addr.size() != n0 + 1 || log_req(n0) !== {1'b0, 32'h100}) begin
      miscompares++;
      $display("FAIL rr_victim: got %h, %0d reqs, first %h want cafe0000, 1 req 0_00000100",
               d, log_addr.size() - n0, log_req(n0));
    end
  endtask

  task automatic test_stall();
    logic [31:0] d; int lat; int cyc;
    stall_left = 5;
    cpu_issue(32'h208, 1'b0, 4'h0, 32'h0);
    cyc = 0;
    while (!mem_req_valid && cyc < 50) begin @(negedge clk); cyc++; end
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if ({mem_req_valid, mem_req_we, mem_req_addr, cpu_req_ready} !== {1'b1, 1'b0, 32'h200, 1'b0}) begin
        miscompares++;
        $display("FAIL stall_hold[%0d]: valid %b we %b addr %h rdy %b want 1 0 00000200 0",
                 i, mem_req_valid, mem_req_we, mem_req_addr, cpu_req_ready);
      end
      @(negedge clk);
    end
    cpu_wait(d, lat);
    vectors++;
    if (d !== 32'hD0000202) begin miscompares++; $display("FAIL stall_rdata: got %h want d0000202", d); end
  endtask

  task automatic test_flush();
    logic [31:0] d; int lat; int n0; int cyc; int pulses;
    cpu_issue(32'h900, 1'b1, 4'b1111, 32'h99990000);
    cpu_wait(d, lat);
    cpu_issue(32'h600, 1'b1, 4'b1111, 32'h12345678);
    cpu_wait(d, lat);
    vectors++;
    if (d !== 32'h12345678) begin miscompares++; $display("FAIL write_miss: got %h want 12345678", d); end
    n0 = log_addr.size();
    @(negedge clk);
    flush = 1'b1;
    #1;
    vectors++;
    if (cpu_req_ready !== 1'b0) begin miscompares++; $display("FAIL flush_ready: got %b want 0", cpu_req_ready); end
    pulses = 0;
    cyc = 0;
    while (cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (flush_done) begin pulses++; break; end
    end
    flush = 1'b0;
    repeat (5) begin @(negedge clk); if (flush_done) pulses++; end
    vectors++;
    if (pulses != 1) begin miscompares++; $display("FAIL flush_done: got %0d pulses want 1", pulses); end
    vectors++;
    if (log_addr.size() != n0 + 2 || log_req(n0) !== {1'b1, 32'h900} || log_req(n0 + 1) !== {1'b1, 32'h600}) begin
      miscompares++;
      $display("FAIL flush_wbs: %0d reqs, %h then %h want 2: 1_00000900 then 1_00000600",
               log_addr.size() - n0, log_req(n0), log_req(n0 + 1));
    end
    vectors++;
    if (log_data(n0) !== {32'hD0000903, 32'hD0000902, 32'hD0000901, 32'h99990000} ||
        log_data(n0 + 1) !== {32'hD0000603, 32'hD0000602, 32'hD0000601, 32'h12345678}) begin
      miscompares++; $display("FAIL flush_data: got %h / %h", log_data(n0), log_data(n0 + 1));
    end
    n0 = log_addr.size();
    cpu_issue(32'h900, 1'b0, 4'h0, 32'h0);
    cpu_wait(d, lat);
    vectors++;
    if (d !== 32'h99990000 || lat != 2) begin
      miscompares++; $display("FAIL post_flush_hit0: got %h lat %0d want 99990000 lat 2", d, lat);
    end
    cpu_issue(32'h604, 1'b0, 4'h0, 32'h0);
    cpu_wait(d, lat);
    vectors++;
    if (d !== 32'hD0000601 || lat != 2 || log_addr.size() != n0) begin
      miscompares++;
      $display("FAIL post_flush_hit1: got %h lat %0d reqs %0d want d0000601 lat 2 reqs 0",
               d, lat, log_addr.size() - n0);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] d; int lat; int n0; int cyc;
    ram_hang = 1'b1;
    cpu_issue(32'h300, 1'b0, 4'h0, 32'h0);
    cyc = 0;
    while (!mem_req_valid && cyc < 50) begin @(negedge clk); cyc++; end
    vectors++;
    if (mem_req_addr !== 32'h300) begin miscompares++; $display("FAIL hang_fill_addr: got %h want 00000300", mem_req_addr); end
    @(posedge clk);
    #2 RESET = 1'b1;
    #1;
    vectors++;
    if ({mem_req_valid, cpu_resp_valid, cpu_req_ready} !== 3'b001) begin
      miscompares++;
      $display("FAIL async_reset: valid/resp/ready got %b want 001",
               {mem_req_valid, cpu_resp_valid, cpu_req_ready});
    end
    @(negedge clk);
    @(negedge clk);
    RESET = 1'b0;
    ram_hang = 1'b0;
    n0 = log_addr.size();
    cpu_issue(32'h300, 1'b0, 4'h0, 32'h0);
    cpu_wait(d, lat);
    vectors++;
    if (d !== 32'hD0000300 || log_addr.size() != n0 + 1 || log_req(n0) !== {1'b0, 32'h300}) begin
      miscompares++;
      $display("FAIL reread_miss: got %h req %h want d0000300 req 0_00000300", d, log_req(n0));
    end
    cpu_issue(32'h104, 1'b0, 4'h0, 32'h0);
    cpu_wait(d, lat);
    vectors++;
    if (d !== 32'h0000AB22 || log_addr.size() != n0 + 2 || log_req(n0 + 1) !== {1'b0, 32'h100}) begin
      miscompares++;
      $display("FAIL reset_invalidates: got %h req %h want 0000ab22 req 0_00000100", d, log_req(n0 + 1));
    end
  endtask

  initial begin
    RESET = 1'b1;
    cpu_req_valid = 1'b0; cpu_req_addr = '0; cpu_req_we = 1'b0;
    cpu_req_be = '0; cpu_req_wdata = '0; flush = 1'b0;
    ram[32'h100] = {32'h44, 32'h33, 32'h22, 32'h11};
    test_reset();
    test_cold_miss();
    test_write_hit();
    test_conflict();
    test_stall();
    test_flush();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
